list_stream_arbiter: RTL and testbench



---
 rtl/list_stream_arbiter_if.sv | 37 +++
 rtl/list_stream_arbiter.sv | 157 +++++++++++++++
 tb/tb_list_stream_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/list_stream_arbiter_if.sv
// list_stream_arbiter_if
//   Bundles the requester-side and downstream-side stream signals of
//   list_stream_arbiter.
//   slave  : arbiter view (takes i_valid/i_data/i_ready, drives o_*)
//   master : environment view (drives i_valid/i_data/i_ready, observes o_*)
//   Signals:
//     i_valid [N]    per-requester valid, bit k = requester k
//     i_data  [N*DW] per-requester data, requester k at [k*DW +: DW]
//     o_ready [N]    per-requester ready, at most one bit high
//     o_valid        downstream valid
//     o_data  [DW]   downstream data
//     o_src   [IW]   source index of o_data
//     i_ready        downstream ready (list_cache o_ready)
interface list_stream_arbiter_if #(
    parameter int DW = 32,
    parameter int N  = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_ready;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic [IW-1:0]   o_src;
    logic            i_ready;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_src
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_src
    );
endinterface

// File: rtl/list_stream_arbiter.sv
// list_stream_arbiter
//   Round-robin arbiter sharing one downstream list_cache stream among N
//   requesters. One requester is granted at a time for up to BURST beats;
//   its beats pass through a registered output stage tagged with o_src.
//   Ports:
//     CLK      system clock, rising edge
//     RESET_N  asynchronous active-low reset
//     bus      list_stream_arbiter_if.slave (i_valid, i_data, o_ready,
//              o_valid, o_data, o_src, i_ready)
//   Build option:
//     LIST_ARB_FIXED_PRIO_EN  defined: fixed priority from index 0, ptr held
//                             at 0. Undefined: round-robin from ptr.
module list_stream_arbiter #(
    parameter int DW    = 32,
    parameter int N     = 4,
    parameter int BURST = 8
) (
    input logic                  CLK,
    input logic                  RESET_N,
    list_stream_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [BW-1:0] beats, beats_n;
    logic          o_valid_q, o_valid_n;
    logic [DW-1:0] o_data_q, o_data_n;
    logic [IW-1:0] o_src_q, o_src_n;

    logic          load;
    logic          accept;
    logic          owner_valid;
    logic [DW-1:0] owner_data;
    logic [IW-1:0] start;
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    logic [IW-1:0] pick;
    logic          found;

    assign load = !o_valid_q || bus.i_ready;

    // Rotate the request vector so the search origin sits at bit 0, take
    // the first set bit, then map back with an explicit wrap at N.
    always_comb begin
`ifdef LIST_ARB_FIXED_PRIO_EN
        start = '0;
`else
        start = ptr;
`endif
        rot   = N'({bus.i_valid, bus.i_valid} >> start);
        found = 1'b0;
        off   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = IW'(j);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        pick = sum[IW-1:0];
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (owner == IW'(k)) begin
                owner_valid = bus.i_valid[k];
                owner_data  = bus.i_data[k*DW +: DW];
            end
        end
    end

    // Ready depends only on state, owner and load; never on i_valid.
    always_comb begin
        bus.o_ready = '0;
        if (state == GRANT) begin
            bus.o_ready = {{(N-1){1'b0}}, load} << owner;
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        beats_n   = beats;
        o_valid_n = o_valid_q;
        o_data_n  = o_data_q;
        o_src_n   = o_src_q;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = pick;
                    beats_n = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                accept = owner_valid && load;
                if (accept) begin
                    o_data_n  = owner_data;
                    o_src_n   = owner;
                    o_valid_n = 1'b1;
                    beats_n   = beats + BW'(1);
                end
                if ((accept && beats_n == BW'(BURST)) || !owner_valid) begin
                    state_n = IDLE;
`ifdef LIST_ARB_FIXED_PRIO_EN
                    ptr_n = '0;
`else
                    ptr_n = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        // The downstream consumed (or never held) the current beat; in IDLE
        // this is what drains the last beat of the previous grant.
        if (load && !accept) begin
            o_valid_n = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            beats     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_src_q   <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            ptr       <= ptr_n;
            beats     <= beats_n;
            o_valid_q <= o_valid_n;
            o_data_q  <= o_data_n;
            o_src_q   <= o_src_n;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_src   = o_src_q;
endmodule

// File: tb/tb_list_stream_arbiter.sv
`timescale 1ns/1ps
module tb_list_stream_arbiter;
    localparam int DW       = 32;
    localparam int N        = 4;
    localparam int BURST    = 8;
    localparam int IW       = $clog2(N);
    localparam int WAIT_MAX = (N - 1) * (BURST + 1) + 1;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    list_stream_arbiter_if #(.DW(DW), .N(N)) bus ();

    list_stream_arbiter #(.DW(DW), .N(N), .BURST(BURST)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] src_q [N][$];   // beats each requester still has to send
    logic [DW-1:0] exp_q [N][$];   // accepted beats awaiting output, per source
    bit            cur_v [N];
    int            valid_pct = 100;
    int            ready_pct = 100;
    int            waitc [N];
    int            rdy_cyc [N];
    int            stall_cnt;

    int            log_src [$];
    logic [DW-1:0] log_data [$];
    int            log_cyc [$];

    int            exp_order [$];
    int            model_ptr = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_src;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Reference: requesters with pending beats are all continuously valid and
    // downstream always ready; each grant takes min(BURST, remaining) beats.
    task automatic model_order(input int cnt [N]);
        int rem [N];
        int total;
        int p;
        int k;
        int take;
        bit got;
        rem = cnt;
        exp_order.delete();
        total = 0;
        for (int i = 0; i < N; i++) total += rem[i];
        while (total > 0) begin
`ifdef LIST_ARB_FIXED_PRIO_EN
            p = 0;
`else
            p = model_ptr;
`endif
            got = 0;
            for (int i = 0; i < N; i++) begin
                k = (p + i) % N;
                if (!got && rem[k] > 0) begin
                    got  = 1;
                    take = (rem[k] < BURST) ? rem[k] : BURST;
                    for (int b = 0; b < take; b++) exp_order.push_back(k);
                    rem[k] -= take;
                    total  -= take;
`ifdef LIST_ARB_FIXED_PRIO_EN
                    model_ptr = 0;
`else
                    model_ptr = (k + 1) % N;
`endif
                end
            end
        end
    endtask

    task automatic check_order(input string name);
        chk(log_src.size() == exp_order.size(), {name, "_len"}, log_src.size(), exp_order.size());
        for (int j = 0; j < exp_order.size() && j < log_src.size(); j++)
            chk(log_src[j] == exp_order[j], name, log_src[j], exp_order[j]);
    endtask

    task automatic push_beats(input int k, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) src_q[k].push_back(base + DW'(i));
    endtask

    task automatic start_phase();
        log_src.delete();
        log_data.delete();
        log_cyc.delete();
        stall_cnt = 0;
        for (int k = 0; k < N; k++) rdy_cyc[k] = -1;
    endtask

    task automatic drain(input string name);
        int  n;
        bit  busy;
        n = 0;
        do begin
            @(negedge CLK);
            busy = 0;
            for (int k = 0; k < N; k++)
                if (src_q[k].size() != 0 || exp_q[k].size() != 0) busy = 1;
            n++;
        end while (busy && n < 5000);
        chk(!busy, name, busy, 0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_outputs(input int cnt, input string name);
        int n;
        n = 0;
        while (log_src.size() < cnt && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(log_src.size() >= cnt, name, log_src.size(), cnt);
    endtask

    // Requester and downstream driver, one update just after each rising edge.
    initial begin
        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            for (int k = 0; k < N; k++) begin
                if (!cur_v[k] && src_q[k].size() > 0 && int'($urandom_range(99)) < valid_pct)
                    cur_v[k] = 1;
                if (src_q[k].size() == 0) cur_v[k] = 0;
                bus.i_valid[k]          = cur_v[k];
                bus.i_data[k*DW +: DW]  = cur_v[k] ? src_q[k][0] : '0;
            end
            bus.i_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    task automatic monitor_step();
        bit            load;
        int            s;
        logic [DW-1:0] e;
        load = !bus.o_valid || bus.i_ready;
        chk($countones(bus.o_ready) <= 1, "ready_onehot", $countones(bus.o_ready), 1);
        if (prev_stall) begin
            chk(bus.o_valid == 1'b1, "stall_valid", bus.o_valid, 1);
            chk(bus.o_data == prev_data, "stall_data", bus.o_data, prev_data);
            chk(bus.o_src == prev_src, "stall_src", bus.o_src, prev_src);
        end
        if (bus.o_valid && !bus.i_ready) begin
            stall_cnt++;
            chk(bus.o_ready == '0, "stall_ready", bus.o_ready, 0);
        end
        prev_stall = bus.o_valid && !bus.i_ready;
        prev_data  = bus.o_data;
        prev_src   = bus.o_src;
        if (bus.o_valid && bus.i_ready) begin
            s = int'(bus.o_src);
            if (s >= N || exp_q[s].size() == 0) begin
                chk(0, "unexpected_beat", s, -1);
            end else begin
                e = exp_q[s].pop_front();
                chk(bus.o_data == e, "data_order", bus.o_data, e);
            end
            log_src.push_back(s);
            log_data.push_back(bus.o_data);
            log_cyc.push_back(cyc);
        end
        for (int k = 0; k < N; k++) begin
            if (bus.o_ready[k] && rdy_cyc[k] < 0) rdy_cyc[k] = cyc;
            if (bus.i_valid[k]) begin
                if (bus.o_ready[k]) begin
`ifndef LIST_ARB_FIXED_PRIO_EN
                    chk(waitc[k] <= WAIT_MAX, "wait_bound", waitc[k], WAIT_MAX);
`endif
                    waitc[k] = 0;
                    if (src_q[k].size() > 0) exp_q[k].push_back(src_q[k].pop_front());
                    cur_v[k] = 0;
                end else if (load) begin
                    waitc[k]++;
                end
            end else begin
                waitc[k] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                prev_stall = 1'b0;
                for (int k = 0; k < N; k++) waitc[k] = 0;
            end else begin
                monitor_step();
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: actual timeout required finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int cnt [N];
        int t0;
        logic [DW-1:0] r;

        start_phase();
        repeat (3) @(negedge CLK);
        chk(bus.o_valid == 1'b0, "rst_valid", bus.o_valid, 0);
        chk(bus.o_data == '0, "rst_data", bus.o_data, 0);
        chk(bus.o_src == '0, "rst_src", bus.o_src, 0);
        chk(bus.o_ready == '0, "rst_ready", bus.o_ready, 0);
        #2 RESET_N = 1'b1;
        model_ptr = 0;
        repeat (2) @(negedge CLK);

        // Single requester 2, three beats, downstream always ready.
        start_phase();
        #2;
        push_beats(2, 3, 32'hA0);
        t0 = cyc + 1;
        drain("t1_drain");
        chk(rdy_cyc[2] == t0 + 1, "t1_ready_cycle", rdy_cyc[2], t0 + 1);
        chk(log_src.size() == 3, "t1_count", log_src.size(), 3);
        for (int j = 0; j < 3 && j < log_src.size(); j++) begin
            chk(log_cyc[j] == t0 + 2 + j, "t1_out_cycle", log_cyc[j], t0 + 2 + j);
            chk(log_src[j] == 2, "t1_src", log_src[j], 2);
            chk(log_data[j] == 32'hA0 + DW'(j), "t1_data", log_data[j], 32'hA0 + j);
        end
        chk(bus.o_ready == '0, "t1_idle_ready", bus.o_ready, 0);
        cnt = '{0, 0, 3, 0};
        model_order(cnt);

        // Burst limit: 20 beats from requester 1 split 8/8/4, one idle cycle between.
        start_phase();
        #2;
        push_beats(1, 20, 32'h100);
        t0 = cyc + 1;
        drain("t2_drain");
        cnt = '{0, 20, 0, 0};
        model_order(cnt);
        check_order("t2_order");
        for (int j = 0; j < 20 && j < log_cyc.size(); j++)
            chk(log_cyc[j] == t0 + 2 + j + j / BURST, "t2_out_cycle", log_cyc[j], t0 + 2 + j + j / BURST);

        // All requesters continuously valid.
        start_phase();
        #2;
        for (int k = 0; k < N; k++) push_beats(k, 12, DW'(32'h1000 * (k + 1)));
        drain("t3_drain");
        cnt = '{12, 12, 12, 12};
        model_order(cnt);
        check_order("t3_order");

        // Backpressure: downstream stalls for 5 cycles mid-burst.
        start_phase();
        #2;
        push_beats(0, 10, 32'h2000);
        wait_outputs(3, "t4_wait");
        ready_pct = 0;
        repeat (5) @(negedge CLK);
        ready_pct = 100;
        drain("t4_drain");
        chk(stall_cnt == 5, "t4_stall_cycles", stall_cnt, 5);
        cnt = '{10, 0, 0, 0};
        model_order(cnt);
        check_order("t4_order");

        // Reset mid-burst: move ptr away from 0 first, then interrupt a grant.
        start_phase();
        #2;
        push_beats(2, 2, 32'h3000);
        drain("t5_pre_drain");
        cnt = '{0, 0, 2, 0};
        model_order(cnt);
        check_order("t5_pre_order");
        start_phase();
        #2;
        push_beats(1, 10, 32'h3100);
        wait_outputs(3, "t5_wait");
        #2 RESET_N = 1'b0;
        #1;
        chk(bus.o_valid == 1'b0, "t5_rst_valid", bus.o_valid, 0);
        chk(bus.o_data == '0, "t5_rst_data", bus.o_data, 0);
        chk(bus.o_src == '0, "t5_rst_src", bus.o_src, 0);
        chk(bus.o_ready == '0, "t5_rst_ready", bus.o_ready, 0);
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            cur_v[k] = 0;
        end
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        model_ptr = 0;
        start_phase();
        push_beats(1, 2, 32'h3200);
        push_beats(3, 2, 32'h3300);
        drain("t5_post_drain");
        cnt = '{0, 2, 0, 2};
        model_order(cnt);
        check_order("t5_post_order");

        // Randomised valid/ready traffic.
        start_phase();
        valid_pct = 60;
        ready_pct = 70;
        #2;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 50; i++) begin
                r = $urandom;
                src_q[k].push_back(r);
            end
        end
        drain("t6_drain");
        chk(log_src.size() == N * 50, "t6_count", log_src.size(), N * 50);
        valid_pct = 100;
        ready_pct = 100;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
